// File: rtl/output_buffer_ctrl.sv
// rtl/output_buffer_ctrl.sv - circular byte buffer feeding the serial transmitter
// Bytes leave in write order through a load/busy handshake; busy is resynchronized locally.
module output_buffer_ctrl #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   flush,
  input  logic                   tx_busy_async,
  output logic                   tx_load,
  output logic [WIDTH-1:0]       tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   load_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_e;
  state_e state_q, state_d;

  logic             busy_meta_q, busy_sync_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    count_q, count_d;
  logic             empty_q, full_q, overflow_q, load_err_q;
  logic [WIDTH-1:0] tx_data_q;
  logic [TW-1:0]    tmo_q;
  logic             start, pop, push, expire;

  // Both flops reset to busy so nothing is handed off until the transmitter is seen idle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_meta_q <= 1'b1;
      busy_sync_q <= 1'b1;
    end else begin
      busy_meta_q <= tx_busy_async;
      busy_sync_q <= busy_meta_q;
    end
  end

  assign start  = (state_q == IDLE) && !empty_q && !busy_sync_q && !flush;
  assign pop    = (state_q == LOAD) && !flush;
  assign push   = wr_en && !flush && (!full_q || pop);
  assign expire = (state_q == WAIT_BUSY) && !busy_sync_q && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + 1'b1;
    else if (pop && !push)  count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_sync_q) state_d = WAIT_DONE;
        else if (expire) state_d = IDLE;
      end
      WAIT_DONE: if (!busy_sync_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_load = (state_q == LOAD);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      load_err_q <= 1'b0;
      tx_data_q  <= '0;
      tmo_q      <= '0;
    end else begin
      if (flush) begin
        wp_q <= '0;
        rp_q <= '0;
      end else begin
        if (push) wp_q <= wp_q + 1'b1;
        if (pop)  rp_q <= rp_q + 1'b1;
      end
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(DEPTH));
      overflow_q <= wr_en && full_q && !pop && !flush;
      load_err_q <= load_err_q | expire;
      if (start) tx_data_q <= mem_q[rp_q];
      if (state_q == LOAD) tmo_q <= '0;
      else if (state_q == WAIT_BUSY && !busy_sync_q) tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign load_err = load_err_q;
endmodule

// File: doc/output_buffer_ctrl.md
# output_buffer_ctrl

Controller for the output byte buffer. It accepts bytes from the packet side into a circular buffer and sequences them one at a time into the serial transmitter. Hand-off is a load/busy handshake, with the transmitter's asynchronous busy flag synchronized inside the block. The block sits between the packet assembler and the bit-stuffing/NRZI transmitter in the output path.

## Interface
- DEPTH, 8: buffer entries; must be a power of two, at least 2.
- WIDTH, 8: data byte width.
- TIMEOUT, 15: maximum cycles spent in WAIT_BUSY before the load is abandoned; TIMEOUT ≥ 4.

Ports (reset n_rst, asynchronous, active-low; clock clk):
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe; samples wr_data on the rising clk edge.
- wr_data  in  WIDTH  byte to enqueue.
- flush  in  1  discards all buffered bytes.
- tx_busy_async  in  1  transmitter busy flag from the transmitter domain; asynchronous.
- tx_load  out  1  one-cycle pulse; tx_data is valid for the transmitter to capture.
- tx_data  out  WIDTH  byte being handed off; holds its value between loads.
- count  out  $clog2(DEPTH)+1  number of bytes currently buffered.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  one-cycle pulse when a write is rejected.
- load_err  out  1  sticky flag; set on a handshake timeout and cleared only by reset.

## Operation
- Busy synchronizer:
  - Two flops in series; both reset to 1.
  - tx_busy_s is the second flop's output.
  - The block therefore treats the transmitter as busy during reset and for 2 cycles after reset.
- Buffer:
  - Storage is DEPTH×WIDTH registers, addressed by write pointer wp and read pointer rp.
  - Each pointer is $clog2(DEPTH) bits and wraps from DEPTH-1 to 0.
  - count increments on an accepted write, decrements on a pop, and is unchanged when both happen in the same cycle.
- Write acceptance:
  - A write is accepted when wr_en=1 and either count<DEPTH or a pop occurs in the same cycle.
  - A write is rejected when wr_en=1, full=1 and no pop occurs. A rejected write raises overflow for 1 cycle and leaves the buffer unchanged.
- flush:
  - Next edge: wp=rp=0 and count=0.
  - flush overrides any write or pop in the same cycle; no overflow pulse is generated.
  - The FSM is unaffected, except that the IDLE→LOAD transition is suppressed in a flush cycle.
- FSM (reset state IDLE):
  - IDLE: if !empty, !tx_busy_s and !flush, then tx_data <= mem[rp] and go to LOAD.
  - LOAD: tx_load=1 (Moore output); pop the head entry (rp+1, count-1); go to WAIT_BUSY; clear the timeout counter.
  - WAIT_BUSY: if tx_busy_s=1, go to WAIT_DONE. Otherwise increment the counter; when it reaches TIMEOUT, set load_err and go to IDLE.
  - WAIT_DONE: if tx_busy_s=0, go to IDLE.
- Bytes leave in exactly the order they were written. A timed-out byte is not retried.

## Timing
- Reset values: tx_load=0, tx_data=0, count=0, empty=1, full=0, overflow=0, load_err=0, state=IDLE, both sync flops=1.
- count, empty and full are registered; they update on the edge that performs the write or pop.
- Write-to-load latency, with the transmitter idle and the buffer empty:
  - wr_en is sampled at edge k.
  - tx_load is high for the cycle between edges k+1 and k+2.
- Busy latency: a change on tx_busy_async appears on tx_busy_s 2 edges later.
- Minimum spacing between loads:
  - LOAD (1 cycle), then WAIT_BUSY (at least 1), then WAIT_DONE (at least 1), then IDLE (1).
  - This gives at least 4 cycles between tx_load pulses.
- Full-with-pop:
  - A write that coincides with the LOAD pop while full=1 is accepted.
  - count stays at DEPTH and overflow stays 0.
- Pointer wrap: after DEPTH writes and DEPTH pops, wp=rp=0 with no loss or duplication.
- Reset mid-operation (any state): all state returns to reset values immediately. Buffered bytes are lost.
- Flush during WAIT_BUSY or WAIT_DONE: the in-flight byte is still handshaked normally. Only the queued bytes are discarded.

## Test plan
- Reset and startup:
  - Assert n_rst=0 with tx_busy_async=0; all outputs must take their reset values.
  - Write 0xA5 at the first edge after release. tx_load must not rise before tx_busy_s has gone low, 2 edges after release.
  - tx_data must then be 0xA5.
- Ordered drain:
  - Write 0x11, 0x22, 0x33 on consecutive edges.
  - Emulate the transmitter: raise busy 1 cycle after each tx_load, hold it 5 cycles, then drop it.
  - Required: three loads in order 0x11, 0x22, 0x33; count returns to 0; load spacing ≥ 4 cycles.
- Full and overflow:
  - With busy held at 1, write 9 bytes with DEPTH=8.
  - Required: full=1 after the 8th write; overflow pulses once on the 9th; count=8.
  - Release busy; the 8 original bytes drain in order.
  - Then run 8 more writes and 8 more drains; no loss, confirming wrap.
- Simultaneous write and pop at full: with count=8, align wr_en with the LOAD cycle. Required: overflow=0, count stays 8, and the new byte drains last.
- Timeout:
  - Load a byte while busy never rises.
  - Required: load_err=1 exactly TIMEOUT cycles after entering WAIT_BUSY; FSM returns to IDLE; the next byte loads normally.
  - load_err stays 1 until reset.
- Flush and mid-operation reset:
  - Buffer 5 bytes, then assert flush during WAIT_DONE. The in-flight byte must complete; count=0; no further tx_load.
  - Repeat with n_rst pulsed low instead of flush. Required: immediate return to reset values.
